// File: rtl/time_keeper_pkg.sv
// time_keeper_pkg: shared time limits, field widths and the hh:mm:ss record
package time_keeper_pkg;
  localparam int HRS_W = 5;
  localparam int MS_W = 6;
  localparam logic [HRS_W-1:0] HRS_MAX = 5'd23;
  localparam logic [MS_W-1:0] MIN_MAX = 6'd59;
  localparam logic [MS_W-1:0] SEC_MAX = 6'd59;
  typedef struct packed {
    logic [HRS_W-1:0] hh;
    logic [MS_W-1:0]  mm;
    logic [MS_W-1:0]  ss;
  } hms_t;
  function automatic hms_t sanitize(input logic [HRS_W-1:0] h, input logic [MS_W-1:0] m, input logic [MS_W-1:0] s);
    hms_t r;
    r.hh = h > HRS_MAX ? HRS_MAX : h;
    r.mm = m > MIN_MAX ? MIN_MAX : m;
    r.ss = s > SEC_MAX ? SEC_MAX : s;
    return r;
  endfunction
endpackage

// File: rtl/time_keeper_tick_prescaler.sv
// tick_prescaler: divides clk down to a one-cycle tick every TICK_DIV cycles
module tick_prescaler #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == LAST;
  assign cnt_d = (clr || tick) ? '0 : cnt_q + CW'(1);
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/time_keeper.sv
// time_keeper: loadable HH:MM:SS wall clock advanced by an internal 1 s tick.
// Define ALARM_EN to add the alarm-time register and alarm flag ports.
module time_keeper #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [4:0] in_hrs,
  input  logic [5:0] in_min,
  input  logic [5:0] in_sec,
  output logic [4:0] hrs,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       sec_tick,
  output logic       day_wrap
`ifdef ALARM_EN
  ,
  output logic       alarm,
  input  logic       alarm_set,
  input  logic       alarm_clr
`endif
);
  import time_keeper_pkg::*;
  hms_t time_q, time_d, in_s, inc_t;
  logic tick, run_tick, s_w, m_w, h_w, sec_tick_q, day_wrap_q;
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk (clk),
    .rst (rst),
    .clr (load),
    .tick(tick)
  );
  assign in_s = sanitize(in_hrs, in_min, in_sec);
  // a tick coinciding with load is dropped so the loaded value is shown intact
  assign run_tick = tick & ~load;
  assign s_w = time_q.ss >= SEC_MAX;
  assign m_w = time_q.mm >= MIN_MAX;
  assign h_w = time_q.hh >= HRS_MAX;
  always_comb begin
    inc_t.ss = s_w ? '0 : time_q.ss + MS_W'(1);
    inc_t.mm = s_w ? (m_w ? '0 : time_q.mm + MS_W'(1)) : time_q.mm;
    inc_t.hh = (s_w && m_w) ? (h_w ? '0 : time_q.hh + HRS_W'(1)) : time_q.hh;
    time_d = load ? in_s : run_tick ? inc_t : time_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      time_q     <= '0;
      sec_tick_q <= 1'b0;
      day_wrap_q <= 1'b0;
    end else begin
      time_q     <= time_d;
      sec_tick_q <= run_tick;
      day_wrap_q <= run_tick & s_w & m_w & h_w;
    end
  end
  assign hrs = time_q.hh;
  assign min = time_q.mm;
  assign sec = time_q.ss;
  assign sec_tick = sec_tick_q;
  assign day_wrap = day_wrap_q;
`ifdef ALARM_EN
  hms_t alm_q, alm_d;
  logic alarm_q, alarm_d;
  // sec_tick only follows run-mode increments, so loaded times never match
  assign alm_d = alarm_set ? in_s : alm_q;
  assign alarm_d = alarm_clr ? 1'b0 : (sec_tick_q && time_q == alm_q) ? 1'b1 : alarm_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      alm_q   <= '0;
      alarm_q <= 1'b0;
    end else begin
      alm_q   <= alm_d;
      alarm_q <= alarm_d;
    end
  end
  assign alarm = alarm_q;
`endif
endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: directed vector table plus multi-cycle sequences for time_keeper
module tb_time_keeper;
  logic clk = 1'b0;
  logic rst, load;
  logic [4:0] in_hrs;
  logic [5:0] in_min, in_sec;
  logic [4:0] hrs;
  logic [5:0] min, sec;
  logic sec_tick, day_wrap;
  int total = 0;
  int bad = 0;
`ifdef ALARM_EN
  logic alarm, alarm_set, alarm_clr;
`endif
  time_keeper #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .load(load),
    .in_hrs(in_hrs), .in_min(in_min), .in_sec(in_sec),
    .hrs(hrs), .min(min), .sec(sec),
    .sec_tick(sec_tick), .day_wrap(day_wrap)
`ifdef ALARM_EN
    , .alarm(alarm), .alarm_set(alarm_set), .alarm_clr(alarm_clr)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [4:0] i_h;
    logic [5:0] i_m;
    logic [5:0] i_s;
    logic [4:0] e_h;
    logic [5:0] e_m;
    logic [5:0] e_s;
  } vec_t;
  vec_t vt[8];
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  task automatic chk_t(input string n, input int h, input int m, input int s, input int st, input int dw);
    chk({n, " hrs"}, hrs, h);
    chk({n, " min"}, min, m);
    chk({n, " sec"}, sec, s);
    chk({n, " sec_tick"}, sec_tick, st);
    chk({n, " day_wrap"}, day_wrap, dw);
  endtask
  // three quiet cycles then the tick cycle showing the new time
  task automatic run_sec(input string n, input int h, input int m, input int s, input int dw);
    for (int i = 0; i < 3; i++) begin
      step();
      chk({n, " quiet sec_tick"}, sec_tick, 0);
    end
    step();
    chk_t(n, h, m, s, 1, dw);
  endtask
  initial begin
    vt[0] = '{5'd5, 6'd6, 6'd7, 5'd5, 6'd6, 6'd7};
    vt[1] = '{5'd30, 6'd61, 6'd60, 5'd23, 6'd59, 6'd59};
    vt[2] = '{5'd23, 6'd59, 6'd59, 5'd23, 6'd59, 6'd59};
    vt[3] = '{5'd24, 6'd60, 6'd59, 5'd23, 6'd59, 6'd59};
    vt[4] = '{5'd0, 6'd0, 6'd0, 5'd0, 6'd0, 6'd0};
    vt[5] = '{5'd12, 6'd34, 6'd56, 5'd12, 6'd34, 6'd56};
    vt[6] = '{5'd23, 6'd59, 6'd55, 5'd23, 6'd59, 6'd55};
    vt[7] = '{5'd23, 6'd59, 6'd55, 5'd23, 6'd59, 6'd55};
    rst = 1'b1; load = 1'b0; in_hrs = '0; in_min = '0; in_sec = '0;
`ifdef ALARM_EN
    alarm_set = 1'b0; alarm_clr = 1'b0;
`endif
    step(); step();
    chk_t("reset", 0, 0, 0, 0, 0);
`ifdef ALARM_EN
    chk("reset alarm", alarm, 0);
`endif
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_t("post-reset quiet", 0, 0, 0, 0, 0);
    end
    step();
    chk_t("first tick", 0, 0, 1, 1, 0);
    step();
    chk("pulse width", sec_tick, 0);
    load = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_hrs = vt[i].i_h; in_min = vt[i].i_m; in_sec = vt[i].i_s;
      step();
      chk_t($sformatf("load vec%0d", i), vt[i].e_h, vt[i].e_m, vt[i].e_s, 0, 0);
    end
    load = 1'b0;
    run_sec("run 56", 23, 59, 56, 0);
    run_sec("run 57", 23, 59, 57, 0);
    run_sec("run 58", 23, 59, 58, 0);
    run_sec("run 59", 23, 59, 59, 0);
    run_sec("day wrap", 0, 0, 0, 1);
    step();
    chk_t("after wrap", 0, 0, 0, 0, 0);
    load = 1'b1; in_hrs = 5'd30; in_min = 6'd61; in_sec = 6'd60;
    for (int i = 0; i < 6; i++) begin
      step();
      chk_t("load held", 23, 59, 59, 0, 0);
    end
    load = 1'b0;
    step(); step(); step();
    chk_t("pre-collision", 23, 59, 59, 0, 0);
    load = 1'b1; in_hrs = 5'd1; in_min = 6'd2; in_sec = 6'd3;
    step();
    chk_t("load on tick", 1, 2, 3, 0, 0);
    load = 1'b0;
    run_sec("after collision", 1, 2, 4, 0);
    load = 1'b1; in_hrs = 5'd12; in_min = 6'd34; in_sec = 6'd56;
    step();
    load = 1'b0;
    step(); step();
    chk_t("mid-second", 12, 34, 56, 0, 0);
    rst = 1'b1;
    step();
    chk_t("mid rst", 0, 0, 0, 0, 0);
    rst = 1'b0;
    run_sec("after mid rst", 0, 0, 1, 0);
`ifdef ALARM_EN
    alarm_set = 1'b1; in_hrs = 5'd0; in_min = 6'd0; in_sec = 6'd3;
    step();
    alarm_set = 1'b0;
    chk_t("alarm_set keeps time", 0, 0, 1, 0, 0);
    chk("alarm after set", alarm, 0);
    load = 1'b1; in_sec = 6'd0;
    step();
    load = 1'b0;
    run_sec("al 1", 0, 0, 1, 0);
    run_sec("al 2", 0, 0, 2, 0);
    run_sec("al 3", 0, 0, 3, 0);
    chk("alarm on match tick", alarm, 0);
    step();
    chk("alarm rise", alarm, 1);
    step(); step(); step();
    chk_t("al 4", 0, 0, 4, 1, 0);
    chk("alarm hold", alarm, 1);
    alarm_clr = 1'b1;
    step();
    alarm_clr = 1'b0;
    chk("alarm clr", alarm, 0);
    load = 1'b1; alarm_set = 1'b1; in_sec = 6'd1;
    step();
    alarm_set = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("load equal no alarm", alarm, 0);
    end
    in_sec = 6'd0;
    step();
    load = 1'b0;
    run_sec("al clr race", 0, 0, 1, 0);
    alarm_clr = 1'b1;
    step();
    alarm_clr = 1'b0;
    chk("clr beats match", alarm, 0);
    step();
    chk("clr beats match later", alarm, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
